// File: rtl/lms_ctr_spi_slave_regs.sv
// ============================================================================
// Module      : lms_ctr_spi_slave_regs
// Description : Mode-0 SPI slave giving an external master read/write access
//               to a fabric register bank. 32-bit frames: R/W flag, 15-bit
//               address, 16-bit data, MSB first. SCLK/MOSI/SS_n are
//               oversampled in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lms_ctr_spi_slave_regs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe,
    output logic [14:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_HDR        = 3'd1,
        S_DATA       = 3'd2,
        S_DONE       = 3'd3,
        S_WAIT_DESEL = 3'd4
    } state_t;

    localparam logic [5:0] c_hdr_last   = 6'd15;
    localparam logic [5:0] c_frame_last = 6'd31;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_prev;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    // Only the 16 most recent bits are ever decoded (header, then data).
    logic [14:0] r_rx;
    logic [15:0] r_tx;
    logic        r_wr_flag;
    logic        r_rd_pend;
    logic        r_rd_d;
    logic        r_miso;
    logic        r_oe;
    logic [14:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;
    logic        r_rd;
    logic        r_frame_err;

    logic        w_sclk_s;
    logic        w_mosi_s;
    logic        w_ss_s;
    logic        w_rise;
    logic        w_fall;
    logic [15:0] w_rx_next;
    logic        w_start;
    logic        w_shift_in;
    logic        w_hdr_done;
    logic        w_frame_done;
    logic        w_err;

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk_s & ~r_sclk_prev;
    assign w_fall    = ~w_sclk_s & r_sclk_prev;
    assign w_rx_next = {r_rx, w_mosi_s};

    // Synchronizers run through reset so the reset state sees the true SS_n level.
    always_ff @(posedge clk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
        r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
        r_sclk_prev <= w_sclk_s;
    end

    // State register; reset lands in WAIT_DESEL if a frame is still selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= w_ss_s ? S_IDLE : S_WAIT_DESEL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle frame events.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_in   = 1'b0;
        w_hdr_done   = 1'b0;
        w_frame_done = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_ss_s) begin
                    w_state_next = S_HDR;
                    w_start      = 1'b1;
                end
            end
            S_HDR: begin
                if (w_ss_s) begin
                    w_state_next = S_IDLE;
                    w_err        = (r_cnt != 6'd0);
                end else if (w_rise) begin
                    w_shift_in = 1'b1;
                    if (r_cnt == c_hdr_last) begin
                        w_state_next = S_DATA;
                        w_hdr_done   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_ss_s) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end else if (w_rise) begin
                    w_shift_in = 1'b1;
                    if (r_cnt == c_frame_last) begin
                        w_state_next = S_DONE;
                        w_frame_done = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (w_ss_s) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DESEL: begin
                if (w_ss_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: shift-in, address/data capture, strobes, read-data shift-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 6'd0;
            r_rx        <= 15'd0;
            r_tx        <= 16'd0;
            r_wr_flag   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_d      <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_addr      <= 15'd0;
            r_wdata     <= 16'd0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr        <= 1'b0;
            r_rd        <= r_rd_pend;
            r_rd_pend   <= 1'b0;
            r_rd_d      <= r_rd;
            r_frame_err <= w_err;
            r_oe        <= ~w_ss_s;

            if (w_start) begin
                r_cnt <= 6'd0;
            end
            if (w_shift_in) begin
                r_rx  <= w_rx_next[14:0];
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_hdr_done) begin
                r_addr    <= w_rx_next[14:0];
                r_wr_flag <= w_rx_next[15];
                r_rd_pend <= ~w_rx_next[15];
            end
            if (w_frame_done && r_wr_flag) begin
                r_wdata <= w_rx_next;
                r_wr    <= 1'b1;
            end

            // Read data arrives one clk after the read strobe.
            if (r_rd_d) begin
                r_tx <= reg_rdata;
            end

            // MISO only carries data during the data phase of a selected read.
            if (r_state == S_DATA && !r_wr_flag && !w_ss_s) begin
                if (w_fall) begin
                    r_miso <= r_tx[15];
                    r_tx   <= {r_tx[14:0], 1'b0};
                end
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    assign MISO      = r_miso;
    assign MISO_oe   = r_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lms_ctr_spi_slave_regs.sv
// ============================================================================
// Module      : tb_lms_ctr_spi_slave_regs
// Description : Self-checking bench for lms_ctr_spi_slave_regs. A bus-
//               functional SPI master drives frames; expected register-port
//               events are queued and checked by a strobe monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lms_ctr_spi_slave_regs;

    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [14:0] addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SS_n = 1'b1;
    logic        MISO;
    logic        MISO_oe;
    logic [14:0] reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        busy;
    logic        frame_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  sb[$];
    ev_t  mon_e;
    logic [1:0]  mon_kind;
    logic [15:0] mem [0:255];

    lms_ctr_spi_slave_regs #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO),
        .MISO_oe   (MISO_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Register-bank model: registered read, poison value when not reading.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h45] <= 16'h5A5A;
        end else if (reg_wr) begin
            mem[reg_addr[7:0]] <= reg_wdata;
        end
        reg_rdata <= reg_rd ? mem[reg_addr[7:0]] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] kind, input logic [14:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (reg_wr || reg_rd || frame_err)) begin
            chk("strobe_excl", 32'(reg_wr) + 32'(reg_rd) + 32'(frame_err), 32'd1);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e    = sb.pop_front();
                mon_kind = reg_wr ? K_WR : (reg_rd ? K_RD : K_ERR);
                chk("ev_kind", 32'(mon_kind), 32'(mon_e.kind));
                if (mon_e.kind != K_ERR) chk("ev_addr", 32'(reg_addr), 32'(mon_e.addr));
                if (mon_e.kind == K_WR) chk("ev_wdata", 32'(reg_wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic select_slave();
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic deselect_slave(input int gap);
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Mode-0 master: drive MOSI while SCLK low, sample MISO on the rise.
    task automatic spi_bits(input logic [31:0] word, input int nbits,
                            output logic [31:0] rx, output logic extra);
        rx    = 32'h0;
        extra = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 32) ? word[31-i] : 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            if (i < 32) rx[31-i] = MISO;
            else        extra = extra | MISO;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    logic [31:0] rx;
    logic        extra;

    initial begin
        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_MISO", 32'(MISO), 32'd0);
        chk("rst_MISO_oe", 32'(MISO_oe), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_strobes", {29'd0, reg_wr, reg_rd, frame_err}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write frame
        sb.push_back(mk(K_WR, 15'h0123, 16'hABCD));
        select_slave();
        chk("sel_MISO_oe", 32'(MISO_oe), 32'd1);
        spi_bits(32'h8123_ABCD, 32, rx, extra);
        chk("wr_busy", 32'(busy), 32'd1);
        deselect_slave(8);
        chk("wr_miso_zero", rx, 32'h0);
        chk("wr_addr_held", 32'(reg_addr), 32'h0123);
        chk("desel_MISO_oe", 32'(MISO_oe), 32'd0);
        chk("wr_drain", 32'(sb.size()), 32'd0);

        // Read frame
        sb.push_back(mk(K_RD, 15'h0045, 16'h0000));
        select_slave();
        spi_bits(32'h0045_0000, 32, rx, extra);
        deselect_slave(8);
        chk("rd_miso", rx, 32'h0000_5A5A);
        chk("rd_drain", 32'(sb.size()), 32'd0);

        // Truncated write then a full frame
        sb.push_back(mk(K_ERR, 15'h0, 16'h0));
        select_slave();
        spi_bits(32'h8077_BEEF, 20, rx, extra);
        deselect_slave(8);
        chk("trunc_drain", 32'(sb.size()), 32'd0);
        sb.push_back(mk(K_WR, 15'h0022, 16'h1234));
        select_slave();
        spi_bits(32'h8022_1234, 32, rx, extra);
        deselect_slave(8);
        chk("post_trunc_drain", 32'(sb.size()), 32'd0);

        // Reset in the middle of a frame
        select_slave();
        spi_bits(32'h8033_3333, 10, rx, extra);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("mid_rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("mid_rst_outs", {27'd0, MISO, MISO_oe, busy, reg_wr, reg_rd}, 32'd0);
        reset = 1'b0;
        spi_bits(32'h8033_3333 << 10, 22, rx, extra);
        chk("wait_desel_busy", 32'(busy), 32'd0);
        chk("wait_desel_oe", 32'(MISO_oe), 32'd1);
        deselect_slave(8);
        sb.push_back(mk(K_RD, 15'h0045, 16'h0000));
        select_slave();
        spi_bits(32'h0045_0000, 32, rx, extra);
        deselect_slave(8);
        chk("post_rst_rd_miso", rx, 32'h0000_5A5A);
        chk("post_rst_drain", 32'(sb.size()), 32'd0);

        // Back-to-back frames, minimum deselect gap
        sb.push_back(mk(K_WR, 15'h0001, 16'h1111));
        sb.push_back(mk(K_RD, 15'h0001, 16'h0000));
        select_slave();
        spi_bits(32'h8001_1111, 32, rx, extra);
        deselect_slave(0);
        repeat (4) @(negedge clk);
        select_slave();
        spi_bits(32'h0001_0000, 32, rx, extra);
        deselect_slave(8);
        chk("b2b_rd_miso", rx, 32'h0000_1111);
        chk("b2b_drain", 32'(sb.size()), 32'd0);

        // Over-long write frame: 40 clocks, extra bits ignored
        sb.push_back(mk(K_WR, 15'h0005, 16'hCAFE));
        select_slave();
        spi_bits(32'h8005_CAFE, 40, rx, extra);
        deselect_slave(8);
        chk("long_miso_zero", rx, 32'h0);
        chk("long_extra_miso", 32'(extra), 32'd0);
        chk("long_wdata", 32'(reg_wdata), 32'hCAFE);
        chk("long_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
